// File: rtl/seg7_pkg.sv
// seg7_pkg: constants shared by the 7-segment encoder and decoder paths.
//   - SEG7_0 .. SEG7_F : segment patterns {A,B,C,D,E,F,G}, A in bit 6, G in bit 0
//   - SEG7_BLANK       : all segments off
//   - seg7_state_e     : scan-decoder FSM state encoding
package seg7_pkg;

  localparam logic [6:0] SEG7_0     = 7'h7E;
  localparam logic [6:0] SEG7_1     = 7'h30;
  localparam logic [6:0] SEG7_2     = 7'h6D;
  localparam logic [6:0] SEG7_3     = 7'h79;
  localparam logic [6:0] SEG7_4     = 7'h33;
  localparam logic [6:0] SEG7_5     = 7'h5B;
  localparam logic [6:0] SEG7_6     = 7'h5F;
  localparam logic [6:0] SEG7_7     = 7'h70;
  localparam logic [6:0] SEG7_8     = 7'h7F;
  localparam logic [6:0] SEG7_9     = 7'h7B;
  localparam logic [6:0] SEG7_A     = 7'h77;
  localparam logic [6:0] SEG7_B     = 7'h1F;
  localparam logic [6:0] SEG7_C     = 7'h4E;
  localparam logic [6:0] SEG7_D     = 7'h3D;
  localparam logic [6:0] SEG7_E     = 7'h4F;
  localparam logic [6:0] SEG7_F     = 7'h47;
  localparam logic [6:0] SEG7_BLANK = 7'h00;

  typedef enum logic [1:0] {
    SEG7_IDLE   = 2'd0,
    SEG7_SETTLE = 2'd1,
    SEG7_LOCKED = 2'd2
  } seg7_state_e;

endpackage

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode: combinational inverse of the hex-to-7-segment map.
// Ports:
//   i_Pattern [6:0] : segment pattern, A in bit 6, G in bit 0
//   o_Nibble  [3:0] : decoded hex value (0 for blank or illegal patterns)
//   o_Blank         : pattern is all segments off
//   o_Error         : pattern is neither a hex code nor blank
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] i_Pattern,
  output logic [3:0] o_Nibble,
  output logic       o_Blank,
  output logic       o_Error
);

  always_comb begin
    o_Nibble = 4'h0;
    o_Blank  = 1'b0;
    o_Error  = 1'b0;
    case (i_Pattern)
      SEG7_0:     o_Nibble = 4'h0;
      SEG7_1:     o_Nibble = 4'h1;
      SEG7_2:     o_Nibble = 4'h2;
      SEG7_3:     o_Nibble = 4'h3;
      SEG7_4:     o_Nibble = 4'h4;
      SEG7_5:     o_Nibble = 4'h5;
      SEG7_6:     o_Nibble = 4'h6;
      SEG7_7:     o_Nibble = 4'h7;
      SEG7_8:     o_Nibble = 4'h8;
      SEG7_9:     o_Nibble = 4'h9;
      SEG7_A:     o_Nibble = 4'hA;
      SEG7_B:     o_Nibble = 4'hB;
      SEG7_C:     o_Nibble = 4'hC;
      SEG7_D:     o_Nibble = 4'hD;
      SEG7_E:     o_Nibble = 4'hE;
      SEG7_F:     o_Nibble = 4'hF;
      SEG7_BLANK: o_Blank  = 1'b1;
      default:    o_Error  = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: samples a multiplexed 7-segment bus and recovers the hex
// value shown on each digit, ignoring scan transitions via a stability filter.
//
// Build option: define SEG7_ACTIVE_LOW_EN for common-anode buses; segment
// inputs are then inverted at the input register (digit select is unaffected).
//
// Ports:
//   i_Clk, i_Rst_L          : clock (rising edge), async active-low reset
//   i_Segment_A..G          : segment lines, A -> pattern bit 6, G -> bit 0
//   i_Digit_Sel             : one-hot digit enable from the scan driver
//   o_Digit_Valid           : one-cycle pulse, a stable sample was decoded
//   o_Digit_Index           : digit captured (held until next pulse)
//   o_Binary_Num            : decoded nibble (held until next pulse)
//   o_Blank, o_Error        : blank / illegal pattern, only with the pulse
//   o_Digits                : last legal nibble per digit, digit i at [4i+3:4i]
//   o_Fsm_State             : current FSM state, for observation
//
// Output handshake: o_Digit_Valid is a one-cycle strobe with no back-pressure;
// o_Digit_Index, o_Binary_Num, o_Blank and o_Error are meaningful only in the
// cycle o_Digit_Valid is high.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter  int NUM_DIGITS    = 4,
  parameter  int STABLE_CYCLES = 4,
  parameter  int CNT_W         = $clog2(STABLE_CYCLES + 1),
  localparam int IDX_W         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst_L,
  input  logic                    i_Segment_A,
  input  logic                    i_Segment_B,
  input  logic                    i_Segment_C,
  input  logic                    i_Segment_D,
  input  logic                    i_Segment_E,
  input  logic                    i_Segment_F,
  input  logic                    i_Segment_G,
  input  logic [NUM_DIGITS-1:0]   i_Digit_Sel,
  output logic                    o_Digit_Valid,
  output logic [IDX_W-1:0]        o_Digit_Index,
  output logic [3:0]              o_Binary_Num,
  output logic                    o_Blank,
  output logic                    o_Error,
  output logic [4*NUM_DIGITS-1:0] o_Digits,
  output seg7_state_e             o_Fsm_State
);

  localparam int SMP_W = 7 + NUM_DIGITS;

  logic [6:0] seg_in;
`ifdef SEG7_ACTIVE_LOW_EN
  assign seg_in = ~{i_Segment_A, i_Segment_B, i_Segment_C, i_Segment_D,
                    i_Segment_E, i_Segment_F, i_Segment_G};
`else
  assign seg_in = {i_Segment_A, i_Segment_B, i_Segment_C, i_Segment_D,
                   i_Segment_E, i_Segment_F, i_Segment_G};
`endif

  // s_d is the sample this edge loads; s_q is the registered sample.
  // "s_q == s_prev after the edge" is the same as "s_d == s_q before it",
  // which lets the capture fire in the cycle right after E(STABLE_CYCLES).
  logic [SMP_W-1:0] s_d;
  logic [SMP_W-1:0] s_q;
  assign s_d = {seg_in, i_Digit_Sel};

  logic [NUM_DIGITS-1:0] sel_d;
  logic [NUM_DIGITS-1:0] sel_q;
  logic [6:0]            pat_q;
  assign sel_d = s_d[NUM_DIGITS-1:0];
  assign sel_q = s_q[NUM_DIGITS-1:0];
  assign pat_q = s_q[SMP_W-1:NUM_DIGITS];

  logic sel_d_onehot;
  assign sel_d_onehot = (sel_d != '0) &&
                        ((sel_d & (sel_d - NUM_DIGITS'(1))) == '0);

  logic [IDX_W-1:0] idx_q;
  always_comb begin
    idx_q = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (sel_q[i]) idx_q = IDX_W'(i);
    end
  end

  logic [3:0] dec_nib;
  logic       dec_blank;
  logic       dec_error;

  seg7_pattern_decode u_decode (
    .i_Pattern (pat_q),
    .o_Nibble  (dec_nib),
    .o_Blank   (dec_blank),
    .o_Error   (dec_error)
  );

  seg7_state_e      state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             stable_done;

  assign cnt_inc     = cnt + CNT_W'(1);
  assign stable_done = (cnt_inc == CNT_W'(STABLE_CYCLES));
  assign o_Fsm_State = state;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      s_q           <= '0;
      state         <= SEG7_IDLE;
      cnt           <= '0;
      o_Digit_Valid <= 1'b0;
      o_Digit_Index <= '0;
      o_Binary_Num  <= 4'h0;
      o_Blank       <= 1'b0;
      o_Error       <= 1'b0;
      o_Digits      <= '0;
    end else begin
      s_q           <= s_d;
      o_Digit_Valid <= 1'b0;
      o_Blank       <= 1'b0;
      o_Error       <= 1'b0;
      if (!sel_d_onehot) begin
        state <= SEG7_IDLE;
        cnt   <= '0;
      end else if (s_d != s_q) begin
        // Any segment or select change restarts the filter, including on
        // the edge that would otherwise have completed the count.
        state <= SEG7_SETTLE;
        cnt   <= '0;
      end else if (state != SEG7_LOCKED) begin
        cnt <= cnt_inc;
        if (stable_done) begin
          // Counter stops at STABLE_CYCLES; LOCKED holds it there.
          state         <= SEG7_LOCKED;
          o_Digit_Valid <= 1'b1;
          o_Digit_Index <= idx_q;
          o_Blank       <= dec_blank;
          o_Error       <= dec_error;
          o_Binary_Num  <= (dec_blank || dec_error) ? 4'h0 : dec_nib;
          if (!dec_blank && !dec_error) begin
            o_Digits[4*idx_q +: 4] <= dec_nib;
          end
        end else begin
          state <= SEG7_SETTLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
module tb_seg7_scan_decoder;

  localparam int ND = 4;
  localparam int SC = 4;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic [6:0]    pat = 7'h00;   // logical pattern, A in bit 6
  logic [ND-1:0] sel = '0;
  logic [6:0]    port_pat;
`ifdef SEG7_ACTIVE_LOW_EN
  assign port_pat = ~pat;
`else
  assign port_pat = pat;
`endif

  logic          o_digit_valid;
  logic [1:0]    o_digit_index;
  logic [3:0]    o_binary_num;
  logic          o_blank;
  logic          o_error;
  logic [4*ND-1:0] o_digits;
  logic [1:0]    o_fsm_state;

  seg7_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .i_Clk         (clk),
    .i_Rst_L       (rst_n),
    .i_Segment_A   (port_pat[6]),
    .i_Segment_B   (port_pat[5]),
    .i_Segment_C   (port_pat[4]),
    .i_Segment_D   (port_pat[3]),
    .i_Segment_E   (port_pat[2]),
    .i_Segment_F   (port_pat[1]),
    .i_Segment_G   (port_pat[0]),
    .i_Digit_Sel   (sel),
    .o_Digit_Valid (o_digit_valid),
    .o_Digit_Index (o_digit_index),
    .o_Binary_Num  (o_binary_num),
    .o_Blank       (o_blank),
    .o_Error       (o_error),
    .o_Digits      (o_digits),
    .o_Fsm_State   (o_fsm_state)
  );

  // ---------------- scoreboard ----------------
  int n_cmp   = 0;
  int n_err   = 0;
  int n_pulse = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // A capture happens when a one-hot sample has been seen on exactly
  // SC+1 consecutive edges (the loading edge plus SC repeats).
  logic [6:0]      codes [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                  7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
  logic [6+ND:0]   m_last;
  int              m_run;
  logic            m_valid, m_blank, m_err;
  logic [1:0]      m_idx;
  logic [3:0]      m_num;
  logic [4*ND-1:0] m_digits;

  task automatic model_reset();
    m_last   = '0;
    m_run    = 1;
    m_valid  = 1'b0;
    m_blank  = 1'b0;
    m_err    = 1'b0;
    m_idx    = '0;
    m_num    = '0;
    m_digits = '0;
  endtask

  task automatic model_edge();
    logic [6+ND:0] smp;
    int            hit;
    smp = {pat, sel};
    if (smp === m_last) begin
      if (m_run < 1000) m_run++;
    end else begin
      m_last = smp;
      m_run  = 1;
    end
    m_valid = ($countones(sel) == 1) && (m_run == SC + 1);
    m_blank = 1'b0;
    m_err   = 1'b0;
    if (m_valid) begin
      hit = -1;
      for (int i = 0; i < 16; i++) if (codes[i] == pat) hit = i;
      m_idx = 2'($clog2(sel));
      if (pat == 7'h00) begin
        m_blank = 1'b1;
        m_num   = 4'h0;
      end else if (hit < 0) begin
        m_err = 1'b1;
        m_num = 4'h0;
      end else begin
        m_num = 4'(hit);
        m_digits[4*m_idx +: 4] = 4'(hit);
      end
    end
  endtask

  task automatic check_all();
    chk("valid",  o_digit_valid, m_valid);
    chk("blank",  o_blank,       m_blank);
    chk("error",  o_error,       m_err);
    chk("num",    o_binary_num,  m_num);
    chk("index",  o_digit_index, m_idx);
    chk("digits", o_digits,      m_digits);
  endtask

  // ---------------- driver ----------------
  // Entered at a falling edge; drives, clocks, checks #1 after the edge.
  task automatic step(input logic [6:0] p, input logic [ND-1:0] s, input int n);
    repeat (n) begin
      pat = p;
      sel = s;
      @(posedge clk);
      model_edge();
      #1;
      check_all();
      if (o_digit_valid) n_pulse++;
      @(negedge clk);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    #2;
    check_all();
    chk("reset_state", o_fsm_state, 2'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // single capture, then held with no second pulse
    n_pulse = 0;
    step(7'h5B, 4'b0010, 25);
    chk("t1_pulses", n_pulse, 1);
    chk("t1_digit1", o_digits[7:4], 4'h5);

    // alternating samples never settle
    n_pulse = 0;
    repeat (4) begin
      step(7'h79, 4'b0001, 3);
      step(7'h33, 4'b0001, 3);
    end
    chk("t2_nopulse", n_pulse, 0);
    step(7'h33, 4'b0001, 6);
    chk("t2_pulses", n_pulse, 1);
    chk("t2_num", o_binary_num, 4'h4);

    // scan all four digits
    n_pulse = 0;
    step(7'h7E, 4'b0001, 8);
    step(7'h30, 4'b0010, 8);
    step(7'h47, 4'b0100, 8);
    step(7'h1F, 4'b1000, 8);
    chk("t3_pulses", n_pulse, 4);
    chk("t3_digits", o_digits, 16'hBF10);

    // illegal then blank on digit 2
    step(7'h01, 4'b0100, 8);
    chk("t4_digit2", o_digits[11:8], 4'hF);
    step(7'h00, 4'b0100, 8);

    // non one-hot selects
    n_pulse = 0;
    step(7'h7E, 4'b0011, 10);
    step(7'h7E, 4'b0000, 10);
    chk("t5_nopulse", n_pulse, 0);

    // reset two cycles into SETTLE
    step(7'h30, 4'b1000, 2);
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("t6_state", o_fsm_state, 2'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n   = 1'b1;
    n_pulse = 0;
    step(7'h30, 4'b1000, 8);
    chk("t6_pulses", n_pulse, 1);

    // digit 0 showing "2" (inverted at the port in active-low builds)
    step(7'h6D, 4'b0001, 8);
    chk("t7_num", o_binary_num, 4'h2);

    // randomized scan traffic
    repeat (200) begin
      logic [6:0]    rp;
      logic [ND-1:0] rs;
      case ($urandom_range(0, 5))
        0:       rs = '0;
        1:       rs = ND'($urandom_range(0, 15));
        default: rs = ND'(1) << $urandom_range(0, ND - 1);
      endcase
      case ($urandom_range(0, 5))
        0:       rp = 7'h00;
        1:       rp = 7'($urandom_range(0, 127));
        default: rp = codes[$urandom_range(0, 15)];
      endcase
      step(rp, rs, $urandom_range(1, 8));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
